// File: rtl/memctl_pkg.sv
// Shared constants for the memory controller: FSM encodings, burst and
// timeout defaults, and the word-address width shared with the memory model.
package memctl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_READ   = 2'b01;
  localparam logic [1:0] ST_WRITE  = 2'b10;
  localparam logic [1:0] ST_FINISH = 2'b11;

  localparam int LINEWORDS_DEF = 4;
  localparam int MAXWAIT_DEF   = 15;
  localparam int MEM_ADRW      = 13;

  // Width of a burst index for an n-word line (at least one bit).
  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memctl_if.sv
// Request/response bus between the cache/fill logic (master) and memctl (slave).
interface memctl_if;
  logic        req;
  logic        reqwrite;
  logic        reqline;
  logic [31:0] reqadr;
  logic [31:0] reqwdata;
  logic [3:0]  reqbyteen;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rword;
  logic        reqdone;
  logic        busy;
  logic        err;

  modport master (
    output req, reqwrite, reqline, reqadr, reqwdata, reqbyteen,
    input  ack, rvalid, rdata, rword, reqdone, busy, err
  );

  modport slave (
    input  req, reqwrite, reqline, reqadr, reqwdata, reqbyteen,
    output ack, rvalid, rdata, rword, reqdone, busy, err
  );
endinterface

// File: rtl/memctl_burst.sv
// Burst word counter, critical-word-first wrapping address, and the per-word
// wait counter that flags a missing memdone.
module memctl_burst
  import memctl_pkg::*;
#(
  parameter int LINEWORDS = LINEWORDS_DEF,
  parameter int MAXWAIT   = MAXWAIT_DEF,
  parameter int ADRW      = MEM_ADRW
) (
  input  logic                             ph1,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             active,
  input  logic                             memdone,
  input  logic [ADRW-1:0]                  base,
  output logic [idx_bits(LINEWORDS)-1:0]   cnt,
  output logic [ADRW-1:0]                  memadr,
  output logic                             timeout
);

  localparam int IW = idx_bits(LINEWORDS);
  localparam int WW = $clog2(MAXWAIT + 1);

  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] low;

  // Word index advances on each completed access; the wait counter tracks
  // consecutive edges without memdone and restarts on every completed word.
  always_ff @(posedge ph1) begin
    if (reset || start) begin
      cnt      <= '0;
      wait_cnt <= '0;
    end else if (active) begin
      if (memdone) begin
        cnt      <= cnt + 1'b1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Low index bits wrap inside the aligned line so the requested word goes first.
  assign low     = base[IW-1:0] + cnt;
  assign memadr  = {base[ADRW-1:IW], low};
  assign timeout = active && !memdone && (wait_cnt == WW'(MAXWAIT - 1));

endmodule

// File: rtl/memctl.sv
// Memory controller: accepts word/line requests, sequences them onto the
// memory's address/bidirectional-data/byte-enable/read-write bus, returns read
// words one by one, and aborts with err when memdone never arrives.
module memctl
  import memctl_pkg::*;
#(
  parameter int LINEWORDS = LINEWORDS_DEF,
  parameter int MAXWAIT   = MAXWAIT_DEF,
  parameter int ADRW      = MEM_ADRW
) (
  input  logic            ph1,
  input  logic            reset,
  memctl_if.slave         bus,
  output logic [ADRW-1:0] memadr,
  inout  wire  [31:0]     memdata,
  output logic [3:0]      membyteen,
  output logic            memrwb,
  output logic            memen,
  input  logic            memdone
);

  localparam int IW = idx_bits(LINEWORDS);

  logic [1:0]      state;
  logic            line_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [ADRW-1:0] base_q;
  logic [IW-1:0]   cnt;
  logic            accept;
  logic            active;
  logic            timeout;
  logic            last_word;
  logic            unused_adr_hi;

  assign accept    = (state == ST_IDLE) && bus.req;
  assign active    = (state == ST_READ) || (state == ST_WRITE);
  assign last_word = line_q ? (cnt == IW'(LINEWORDS - 1)) : (cnt == '0);

  // Byte address bits above the memory's word range are don't-care.
  assign unused_adr_hi = ^{bus.reqadr[31:ADRW+2], bus.reqadr[1:0]};

  memctl_burst #(
    .LINEWORDS (LINEWORDS),
    .MAXWAIT   (MAXWAIT),
    .ADRW      (ADRW)
  ) u_burst (
    .ph1     (ph1),
    .reset   (reset),
    .start   (accept),
    .active  (active),
    .memdone (memdone),
    .base    (base_q),
    .cnt     (cnt),
    .memadr  (memadr),
    .timeout (timeout)
  );

  // Capture the request fields at accept time.
  // NOTE: these are pure data registers, always reloaded before use, so they
  // carry no reset; only control state and visible outputs are reset.
  always_ff @(posedge ph1) begin
    if (accept) begin
      line_q  <= bus.reqline & ~bus.reqwrite;
      wdata_q <= bus.reqwdata;
      be_q    <= bus.reqbyteen;
      base_q  <= bus.reqadr[ADRW+1:2];
    end
  end

  // Control FSM: accept, per-word read return, write completion, timeout abort.
  // NOTE: all state here uses non-blocking assignment so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state       <= ST_IDLE;
      bus.ack     <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rword   <= '0;
      bus.reqdone <= 1'b0;
      bus.busy    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.ack     <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.reqdone <= 1'b0;
      bus.err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            bus.ack  <= 1'b1;
            bus.busy <= 1'b1;
            state    <= bus.reqwrite ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (memdone) begin
            bus.rdata  <= memdata;
            bus.rvalid <= 1'b1;
            bus.rword  <= memadr[1:0];
            if (last_word) state <= ST_FINISH;
          end else if (timeout) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (memdone) begin
            state <= ST_FINISH;
          end else if (timeout) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          bus.reqdone <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory bus controls decode straight from state; the data bus is only
  // driven while writing, so memrwb stays 1 everywhere else.
  assign memen     = active;
  assign memrwb    = (state != ST_WRITE);
  assign membyteen = (state == ST_WRITE) ? be_q : 4'b0000;
  assign memdata   = (state == ST_WRITE) ? wdata_q : 32'bz;

endmodule

// File: doc/memctl.md
Name: memctl

Overview:
- Single-clock memory-interface controller directly upstream of the external memory model.
- Accepts word and cache-line requests from the cache/fill logic and serialises them into the memory's address/bidirectional-data/byte-enable/read-write protocol.
- Waits on the memory's `done`, returns read data word by word, and flags a timeout error if `done` never arrives.

Parameters:
- LINEWORDS, 4, words per line burst (power of 2; 2-bit burst index at default).
- MAXWAIT, 15, ph1 edges to wait for memdone per word before aborting with err.
- ADRW, 13, memory word-address width.

Ports:
- ph1  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  1  request valid; held until ack.
- reqwrite  input  1  1 = single-word write, 0 = read.
- reqline  input  1  read only: 1 = LINEWORDS-word burst, 0 = single word.
- reqadr  input  32  byte address; word address = reqadr[ADRW+1:2].
- reqwdata  input  32  write data.
- reqbyteen  input  4  write byte enables (bit0 = data[7:0], little endian).
- ack  output  1  one-cycle pulse: request accepted.
- rvalid  output  1  one-cycle pulse per returned read word.
- rdata  output  32  read word, valid with rvalid.
- rword  output  2  line index of rdata.
- reqdone  output  1  one-cycle pulse when a request completes (read or write).
- busy  output  1  high from accept until reqdone/err.
- err  output  1  one-cycle pulse on timeout; request abandoned.
- memadr  output  ADRW  memory word address.
- memdata  inout  32  driven only in WRITE, else high-Z.
- membyteen  output  4  byte enables; 0 except in WRITE.
- memrwb  output  1  1 = read; 0 only in WRITE.
- memen  output  1  access enable.
- memdone  input  1  access complete (may be constant 1).

Behaviour:
- Reset: state IDLE; busy, ack, rvalid, reqdone, err = 0; rdata = 0; memen = 0; memrwb = 1; membyteen = 0; memdata high-Z.
- memrwb must be 1 in every state except WRITE. The memory writes on any edge with memrwb = 0 regardless of memen.
- States: IDLE, READ, WRITE, FINISH.
- IDLE: when req = 1, latch the request fields, pulse ack, set busy.
  - reqwrite = 1 -> WRITE.
  - reqwrite = 0 -> READ.
  - req while busy is not acked and stays pending until IDLE.
- READ:
  - memen = 1, memrwb = 1.
  - memadr = {base[ADRW-1:2], (base[1:0] + cnt) mod LINEWORDS}: critical word first, wrapping within the aligned line.
  - Edge with memdone = 1: capture memdata into rdata, pulse rvalid with rword = memadr[1:0], increment cnt, clear wait counter.
  - Last word (cnt = LINEWORDS-1, or cnt = 0 for a single-word read): go to FINISH.
  - With memdone constant 1, a line returns one word per cycle (rvalid on 4 consecutive cycles); first rvalid one cycle after ack.
- WRITE:
  - memen = 1, memrwb = 0, membyteen = latched reqbyteen, memdata = latched wdata.
  - On an edge with memdone = 1 -> FINISH.
  - Exactly one memrwb = 0 edge per write when memdone is constant 1.
- FINISH: pulse reqdone, clear busy, return to IDLE. memrwb = 1, memen = 0. The next request can be acked no earlier than the cycle after reqdone.
- Timeout: in READ/WRITE, each edge without memdone increments a wait counter.
  - Reaching MAXWAIT: pulse err, clear busy, go to IDLE.
  - No reqdone; no further rvalid for that request.
- Reset mid-operation: the next edge returns to IDLE with reset outputs. Partial bursts are dropped; no reqdone.
- reqbyteen = 0 write: still performs the bus cycle (no bytes change) and completes normally.
- Address bits above ADRW+1 are ignored.

Decomposition:
- Shared package `memctl_pkg` holds:
  - state encodings (IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10, FINISH = 2'b11);
  - the LINEWORDS and MAXWAIT defaults;
  - the ADRW constant shared with the memory model.
- One sub-module, `memctl_burst`: burst index counter plus wrap-around address generation plus wait counter.
- The FSM and tristate driver stay in memctl.

Test Plan:
- Reset asserted 2 cycles, then released -> memrwb = 1, memen = 0, busy = 0, memdata high-Z; no memory location changes.
- Single read at reqadr 0x0000_0010, memdone = 1 -> ack, next cycle rvalid with rdata = mem[4], rword = 0, then reqdone; memadr = 4.
- Line read at reqadr 0x0000_0028 (word 10) -> rvalid on 4 consecutive cycles with memadr 10, 11, 8, 9 and rword 2, 3, 0, 1; reqdone after the fourth.
- Write reqadr 0x0000_2404 (word 0x901), wdata 0xDEADBEEF, byteen 4'b0011, prior contents 0x12345678 -> memory reads back 0x1234BEEF; exactly one cycle with memrwb = 0.
- memdone held 0 on a read -> err pulses after 15 edges, busy drops, no rvalid; a following read with memdone = 1 completes normally.
- Reset asserted during the 2nd word of a line read -> next cycle IDLE, memen = 0, no further rvalid; a new req is acked after reset drops.
